// File: rtl/spi_read_seq_if.sv
// rtl/spi_read_seq_if.sv - request, SPI byte-stream and data-sink bundle for spi_read_seq
//
// Signals (slave = the sequencer, master = requester/SPI master/sink side):
//   start, addr[AW], len[LW]   read request
//   busy, done                 transaction status
//   spi_in[8], spi_empty       TX byte offered to the SPI master
//   spi_get                    SPI master consumes spi_in
//   spi_out[8], spi_put        RX byte from the SPI master
//   data[8], valid             forwarded data byte, no backpressure
interface spi_read_seq_if #(
  parameter int AW = 24,
  parameter int LW = 8
);
  logic          start;
  logic [AW-1:0] addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [7:0]    spi_in;
  logic          spi_get;
  logic          spi_empty;
  logic [7:0]    spi_out;
  logic          spi_put;
  logic [7:0]    data;
  logic          valid;

  modport slave (
    input  start, addr, len, spi_get, spi_out, spi_put,
    output busy, done, spi_in, spi_empty, data, valid
  );

  modport master (
    output start, addr, len, spi_get, spi_out, spi_put,
    input  busy, done, spi_in, spi_empty, data, valid
  );
endinterface

// File: rtl/spi_read_seq.sv
// rtl/spi_read_seq.sv - serial-memory read sequencer feeding an SPI bit-bang master
//
// Ports:
//   clock    rising-edge system clock
//   reset_n  asynchronous active-low reset
//   bus      spi_read_seq_if.slave: request (start/addr/len), status (busy/done),
//            TX stream (spi_in/spi_get/spi_empty), RX stream (spi_out/spi_put),
//            data sink (data/valid)
module spi_read_seq #(
  parameter int         AW     = 24,
  parameter int         LW     = 8,
  parameter logic [7:0] OPCODE = 8'h03,
  parameter logic [7:0] FILL   = 8'hFF
) (
  input  logic          clock,
  input  logic          reset_n,
  spi_read_seq_if.slave bus
);

  localparam int NA  = AW / 8;
  localparam int HDR = 1 + NA;
  localparam int HB  = $clog2(HDR + 1);
  // One bit wider than either operand so HDR + len can never wrap.
  localparam int CW  = ((LW > HB) ? LW : HB) + 1;

  localparam logic [CW-1:0] HDR_C = CW'(HDR);
  localparam logic [CW-1:0] NA_C  = CW'(NA);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [AW-1:0] addr_sh;
  logic [LW-1:0] len_q;
  logic [CW-1:0] tx_cnt;
  logic [CW-1:0] rx_cnt;
  logic [CW-1:0] total;

  logic          start_ok;
  logic          get_ok;
  logic          put_ok;
  logic          last_put;
  logic          busy_c;
  logic          empty_c;
  logic [7:0]    tx_byte;

  logic          done_q;
  logic          valid_q;
  logic [7:0]    data_q;

  assign total = HDR_C + CW'(len_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    empty_c  = 1'b1;
    tx_byte  = 8'h00;
    start_ok = 1'b0;
    get_ok   = 1'b0;
    put_ok   = 1'b0;
    last_put = 1'b0;
    case (state)
      IDLE: begin
        start_ok = bus.start;
        if (start_ok) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        busy_c  = 1'b1;
        empty_c = (tx_cnt == total);
        if (!empty_c) begin
          if (tx_cnt == '0) begin
            tx_byte = OPCODE;
          end else if (tx_cnt <= NA_C) begin
            // addr_sh is shifted left once per address byte taken, so the
            // current address byte is always in the top octet.
            tx_byte = addr_sh[AW-1 -: 8];
          end else begin
            tx_byte = FILL;
          end
        end
        get_ok   = bus.spi_get && !empty_c;
        put_ok   = bus.spi_put && (rx_cnt != total);
        last_put = put_ok && ((rx_cnt + ONE) == total);
        if (last_put) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_sh <= '0;
      len_q   <= '0;
      tx_cnt  <= '0;
      rx_cnt  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      done_q  <= last_put;
      valid_q <= 1'b0;
      if (start_ok) begin
        addr_sh <= bus.addr;
        len_q   <= bus.len;
        tx_cnt  <= '0;
        rx_cnt  <= '0;
      end
      if (get_ok) begin
        tx_cnt <= tx_cnt + ONE;
        if (tx_cnt != '0) begin
          addr_sh <= addr_sh << 8;
        end
      end
      if (put_ok) begin
        rx_cnt <= rx_cnt + ONE;
        // Header-phase RX bytes carry nothing useful and are dropped.
        if (rx_cnt >= HDR_C) begin
          data_q  <= bus.spi_out;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.spi_empty = empty_c;
  assign bus.spi_in    = tx_byte;
  assign bus.done      = done_q;
  assign bus.valid     = valid_q;
  assign bus.data      = data_q;

endmodule

// File: tb/tb_spi_read_seq.sv
// tb/tb_spi_read_seq.sv - directed self-checking bench for spi_read_seq
module tb_spi_read_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int total = 0;
  int bad   = 0;

  spi_read_seq_if #(.AW(24), .LW(8)) ifc ();

  spi_read_seq #(
    .AW(24),
    .LW(8),
    .OPCODE(8'h03),
    .FILL(8'hFF)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input logic [23:0] a, input logic [7:0] l);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.addr  = a;
    ifc.len   = l;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.addr  = 24'h5A5A5A;
    ifc.len   = 8'hEE;
    chk("start_busy", ifc.busy, 1);
    chk("start_empty", ifc.spi_empty, 0);
    chk("start_spi_in", ifc.spi_in, 8'h03);
  endtask

  // One byte: get, then put one cycle later, then look at the sink.
  task automatic xfer(input logic [7:0] mosi, input logic [7:0] miso, input bit ev, input bit ed);
    @(negedge clk);
    chk("pre_valid", ifc.valid, 0);
    chk("pre_busy", ifc.busy, 1);
    chk("pre_empty", ifc.spi_empty, 0);
    chk("mosi", ifc.spi_in, mosi);
    ifc.spi_get = 1'b1;
    @(negedge clk);
    ifc.spi_get = 1'b0;
    ifc.spi_put = 1'b1;
    ifc.spi_out = miso;
    @(negedge clk);
    ifc.spi_put = 1'b0;
    chk("valid", ifc.valid, ev);
    if (ev) chk("data", ifc.data, miso);
    chk("done", ifc.done, ed);
    chk("busy_after", ifc.busy, !ed);
  endtask

  initial begin
    logic [7:0] exp7 [6];
    exp7 = '{8'h03, 8'h00, 8'h00, 8'h02, 8'hFF, 8'hFF};

    ifc.start   = 1'b0;
    ifc.addr    = '0;
    ifc.len     = '0;
    ifc.spi_get = 1'b0;
    ifc.spi_out = 8'h00;
    ifc.spi_put = 1'b0;

    // reset state
    #2 rst_n = 1'b0;
    #20;
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_valid", ifc.valid, 0);
    chk("rst_data", ifc.data, 0);
    chk("rst_empty", ifc.spi_empty, 1);
    chk("rst_spi_in", ifc.spi_in, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // loopback, addr 123456, len 2
    start_txn(24'h123456, 8'd2);
    xfer(8'h03, 8'h03, 0, 0);
    xfer(8'h12, 8'h12, 0, 0);
    xfer(8'h34, 8'h34, 0, 0);
    xfer(8'h56, 8'h56, 0, 0);
    xfer(8'hFF, 8'hFF, 1, 0);
    xfer(8'hFF, 8'hFF, 1, 1);
    chk("t1_empty_end", ifc.spi_empty, 1);
    @(negedge clk);
    chk("t1_done_once", ifc.done, 0);
    chk("t1_valid_off", ifc.valid, 0);
    // spi_put in IDLE is ignored
    ifc.spi_put = 1'b1;
    ifc.spi_out = 8'h77;
    @(negedge clk);
    ifc.spi_put = 1'b0;
    chk("idle_put_valid", ifc.valid, 0);
    chk("idle_put_data", ifc.data, 8'hFF);
    chk("idle_put_busy", ifc.busy, 0);

    // slave returns A5 5A C3
    start_txn(24'h000100, 8'd3);
    xfer(8'h03, 8'h00, 0, 0);
    xfer(8'h00, 8'h00, 0, 0);
    xfer(8'h01, 8'h00, 0, 0);
    xfer(8'h00, 8'h00, 0, 0);
    xfer(8'hFF, 8'hA5, 1, 0);
    xfer(8'hFF, 8'h5A, 1, 0);
    xfer(8'hFF, 8'hC3, 1, 1);

    // header only
    start_txn(24'hABCDEF, 8'd0);
    xfer(8'h03, 8'h11, 0, 0);
    xfer(8'hAB, 8'h22, 0, 0);
    xfer(8'hCD, 8'h33, 0, 0);
    xfer(8'hEF, 8'h44, 0, 1);

    // start while busy is ignored
    start_txn(24'h000100, 8'd1);
    xfer(8'h03, 8'h00, 0, 0);
    xfer(8'h00, 8'h00, 0, 0);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.addr  = 24'h777777;
    ifc.len   = 8'd5;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("mid_start_busy", ifc.busy, 1);
    chk("mid_start_spi_in", ifc.spi_in, 8'h01);
    xfer(8'h01, 8'h00, 0, 0);
    xfer(8'h00, 8'h00, 0, 0);
    xfer(8'hFF, 8'h3C, 1, 1);
    @(negedge clk);
    chk("t4_single_done", ifc.done, 0);
    chk("t4_idle", ifc.busy, 0);

    // asynchronous reset mid-transaction
    start_txn(24'h000100, 8'd2);
    xfer(8'h03, 8'h00, 0, 0);
    xfer(8'h00, 8'h00, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", ifc.busy, 0);
    chk("ar_empty", ifc.spi_empty, 1);
    chk("ar_spi_in", ifc.spi_in, 0);
    chk("ar_valid", ifc.valid, 0);
    chk("ar_done", ifc.done, 0);
    chk("ar_data", ifc.data, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ar_no_done", ifc.done, 0);
    end
    rst_n = 1'b1;
    start_txn(24'h000010, 8'd1);
    xfer(8'h03, 8'h00, 0, 0);
    xfer(8'h00, 8'h00, 0, 0);
    xfer(8'h00, 8'h00, 0, 0);
    xfer(8'h10, 8'h00, 0, 0);
    xfer(8'hFF, 8'h99, 1, 1);

    // start in the done cycle
    start_txn(24'h000001, 8'd0);
    xfer(8'h03, 8'h00, 0, 0);
    xfer(8'h00, 8'h00, 0, 0);
    xfer(8'h00, 8'h00, 0, 0);
    xfer(8'h01, 8'h00, 0, 1);
    ifc.start = 1'b1;
    ifc.addr  = 24'h00ABCD;
    ifc.len   = 8'd1;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("b2b_busy", ifc.busy, 1);
    chk("b2b_spi_in", ifc.spi_in, 8'h03);
    chk("b2b_done_off", ifc.done, 0);
    xfer(8'h03, 8'h00, 0, 0);
    xfer(8'h00, 8'h00, 0, 0);
    xfer(8'hAB, 8'h00, 0, 0);
    xfer(8'hCD, 8'h00, 0, 0);
    xfer(8'hFF, 8'h42, 1, 1);

    // pipelined: get n+1 with put n, extra get while empty
    start_txn(24'h000002, 8'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 5) chk("p_mosi", ifc.spi_in, exp7[i]);
      else chk("p_empty", ifc.spi_empty, 1);
      chk("p_valid", ifc.valid, 0);
      ifc.spi_get = 1'b1;
      ifc.spi_put = (i >= 1);
      ifc.spi_out = (i == 5) ? 8'hD7 : 8'h20;
    end
    @(negedge clk);
    ifc.spi_get = 1'b0;
    ifc.spi_put = 1'b0;
    chk("p_last_valid", ifc.valid, 1);
    chk("p_last_data", ifc.data, 8'hD7);
    chk("p_done", ifc.done, 1);
    @(negedge clk);
    chk("p_done_off", ifc.done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_read_seq.md
Name: spi_read_seq

Overview:
- Controller that sequences the byte-stream side of the SPI bit-bang master to perform one serial-memory read transaction per request.
- Sources the command byte, address bytes and dummy fill bytes into the master's TX stream.
- Discards the RX bytes received during the header and forwards each data byte to a downstream sink.
- Sits between a requester (boot loader, table fetcher) and the SPI master, replacing a plain ROM byte source.

Parameters:
- AW, 24: address width in bits; must be a multiple of 8; header = 1 + AW/8 bytes.
- LW, 8: width of the length field.
- OPCODE, 8'h03: command byte sent first.
- FILL, 8'hFF: byte sent during the data phase.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; accepted only while busy=0.
- addr  in  AW  read address, latched on accepted start.
- len  in  LW  data byte count, latched on accepted start; 0 = header only.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse when the last expected RX byte has arrived.
- spi_in  out  8  TX byte offered to the SPI master.
- spi_get  in  1  master consumes spi_in; meaningful only while spi_empty=0.
- spi_empty  out  1  no TX byte available; the master ends the frame (cs_n high) once drained.
- spi_out  in  8  RX byte from the master.
- spi_put  in  1  spi_out valid strobe.
- data  out  8  forwarded data byte.
- valid  out  1  one-cycle strobe qualifying data; the sink has no backpressure.

Behaviour:
- Reset values (reset_n low, asynchronous): busy=0, done=0, valid=0, data=0, spi_empty=1, spi_in=0. All counters cleared, FSM in IDLE. Reset mid-transaction abandons it immediately; no done pulse follows.
- Total byte count T = 1 + AW/8 + len, computed at LW+1 bits or wider so it cannot overflow.
- Counters: tx_cnt counts bytes handed over via spi_get; rx_cnt counts RX bytes received via spi_put. Both are independent, because the master may take byte n+1 before delivering RX byte n.
- IDLE: on start with busy=0, latch addr and len, clear both counters, go to RUN. In the next cycle busy=1, spi_empty=0, spi_in=OPCODE. start while busy=1 is ignored entirely.
- RUN, TX side: spi_in is a function of tx_cnt:
  - tx_cnt=0 → OPCODE.
  - tx_cnt=1..AW/8 → address bytes, MSB first.
  - Above that → FILL.
  - spi_get with spi_empty=0 increments tx_cnt; spi_in shows the next byte on the following cycle.
  - spi_empty=1 once tx_cnt=T.
  - spi_get while spi_empty=1 is ignored.
- RUN, RX side: each spi_put increments rx_cnt.
  - If rx_cnt (before the increment) is below 1 + AW/8, the byte is dropped.
  - Otherwise data<=spi_out and valid=1 on the next cycle; latency is 1 clock from spi_put.
- Completion: the spi_put that brings rx_cnt to T causes, on the next cycle, done=1 for one cycle, busy=0, FSM to IDLE. The final valid (if len>0) and done appear in the same cycle.
- start is accepted in the done cycle because busy=0 there. The new transaction begins the next cycle.
- spi_put in IDLE, or after rx_cnt=T, is ignored: no valid and no counter change.
- Simultaneous spi_get and spi_put in one cycle: both counters update independently.
- len=0: T = 1 + AW/8, no valid pulses, done after the last header RX byte.
- addr and len inputs may change freely while busy; only the latched copies are used.

Test Plan:
- Loopback (MISO tied to MOSI), AW=24, start with addr=24'h123456, len=2 → TX stream 03 12 34 56 FF FF; valid pulses exactly twice with data=FF; one done pulse; busy high from the cycle after start through the cycle before done; spi_empty returns to 1 after the sixth spi_get.
- Slave model returning A5 5A C3 after the 4-byte header, len=3, addr=24'h000100 → data sequence A5, 5A, C3; each valid exactly 1 clock after its spi_put.
- len=0, addr=24'hABCDEF → TX stream 03 AB CD EF; zero valid pulses; done after the fourth spi_put.
- start pulsed again mid-transaction with a different addr → ignored; TX bytes and data count unchanged; single done.
- reset_n driven low after 2 bytes transferred → all outputs at reset values asynchronously; no done. After release, a new start with addr=24'h000010, len=1 completes normally.
- start asserted in the done cycle → second transaction starts the next cycle; its first spi_in = 03.
